dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 117 +++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - single-port data memory arbiter between CPU MEM stage and accelerator.
// Define DMEM_ARB_BURST_LIMIT_EN to cap accelerator bursts at 8 slots while the CPU waits.
module dmem_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        iCpu_req,
    input  logic        iCpu_we,
    input  logic [15:0] iCpu_addr,
    input  logic [15:0] iCpu_wdata,
    output logic        oCpu_stall,
    output logic [15:0] oCpu_rdata,
    output logic        oCpu_rvalid,
    input  logic        iAcc_req,
    input  logic        iAcc_we,
    input  logic [15:0] iAcc_addr,
    input  logic [15:0] iAcc_wdata,
    output logic        oAcc_gnt,
    output logic [15:0] oAcc_rdata,
    output logic        oAcc_rvalid,
    output logic        oMem_en,
    output logic        oMem_we,
    output logic [15:0] oMem_addr,
    output logic [15:0] oMem_wdata,
    input  logic [15:0] iMem_rdata
);

    typedef enum logic [1:0] {IDLE, CPU, ACC} state_t;

    state_t state;
    state_t owner;
    logic   cpu_rv_q;
    logic   acc_rv_q;

`ifdef DMEM_ARB_BURST_LIMIT_EN
    logic [3:0] burst_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            burst_cnt <= 4'd0;
        end else if (owner == ACC) begin
            if (burst_cnt != 4'd8) begin
                burst_cnt <= burst_cnt + 4'd1;
            end
        end else begin
            burst_cnt <= 4'd0;
        end
    end
`endif

    // state remembers who owned the previous slot; read responses are tagged by owner
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cpu_rv_q <= 1'b0;
            acc_rv_q <= 1'b0;
        end else begin
            state    <= owner;
            cpu_rv_q <= (owner == CPU) && !iCpu_we;
            acc_rv_q <= (owner == ACC) && !iAcc_we;
        end
    end

    always_comb begin
        owner = IDLE;
        if (!rst) begin
            if (iCpu_req && iAcc_req) begin
                case (state)
                    IDLE:    owner = CPU;
                    CPU:     owner = ACC;
`ifdef DMEM_ARB_BURST_LIMIT_EN
                    ACC:     owner = (burst_cnt < 4'd8) ? ACC : CPU;
`else
                    ACC:     owner = ACC;
`endif
                    default: owner = CPU;
                endcase
            end else if (iCpu_req) begin
                owner = CPU;
            end else if (iAcc_req) begin
                owner = ACC;
            end
        end
    end

    always_comb begin
        oMem_en    = 1'b0;
        oMem_we    = 1'b0;
        oMem_addr  = 16'h0000;
        oMem_wdata = 16'h0000;
        case (owner)
            CPU: begin
                oMem_en    = 1'b1;
                oMem_we    = iCpu_we;
                oMem_addr  = iCpu_addr;
                oMem_wdata = iCpu_wdata;
            end
            ACC: begin
                oMem_en    = 1'b1;
                oMem_we    = iAcc_we;
                oMem_addr  = iAcc_addr;
                oMem_wdata = iAcc_wdata;
            end
            default: begin
                oMem_en = 1'b0;
            end
        endcase
    end

    assign oCpu_stall  = iCpu_req && (owner != CPU);
    assign oAcc_gnt    = (owner == ACC);
    assign oCpu_rdata  = iMem_rdata;
    assign oAcc_rdata  = iMem_rdata;
    // a reset arriving while a read is in flight kills its response
    assign oCpu_rvalid = cpu_rv_q && !rst;
    assign oAcc_rvalid = acc_rv_q && !rst;

endmodule
